// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
`endif
endinterface

// File: rtl/full_sub.sv
// 1-bit full subtractor cell: a[0] - a[1] - a[2] -> y[0] difference, y[1] borrow.
module full_sub (
    input  logic [0:2] a,
    output logic [0:1] y
);
    assign y[0] = a[0] ^ a[1] ^ a[2];
    assign y[1] = (~a[0] & a[1]) | (~a[0] & a[2]) | (a[1] & a[2]);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) around one full_sub cell.
// Define SERIAL_SUB_OVF_EN to add signed-overflow detection (ovf).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    serial_sub_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic [0:2]       cell_in;
    logic [0:1]       cell_out;
    logic             accept;
    logic             last_bit;

    assign cell_in  = {a_sh[0], b_sh[0], brw_q};
    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    full_sub u_cell (
        .a (cell_in),
        .y (cell_out)
    );

    // Result fills from the MSB; written this way so WIDTH=1 needs no special slice.
    always_comb begin
        res_nxt            = res_q >> 1;
        res_nxt[WIDTH-1]   = cell_out[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res_q <= '0;
            brw_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res_q <= res_nxt;
            brw_q <= cell_out[1];
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
        end
    end
`endif

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
`ifdef SERIAL_SUB_OVF_EN
        bus.ovf       = (state_q == DONE) && (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
`endif
    end

    assign bus.diff   = res_q;
    assign bus.borrow = brw_q;

endmodule
